rect_frame_loader: RTL
======================

# rect_frame_loader

Frame-synchronous loader and arbiter for the rectangle/label overlay. It collects rectangle entries (head box, hair box, possibility bytes) from `N_REQ` detector requesters over valid/ready handshakes and writes them into a shadow bank. On each frame-sync rising edge it copies the shadow bank into the active bank and pulses `o_start`. The active bank and `o_start` drive the overlay controller's `i_head_wire` / `i_hair_wire` / `i_posi_wire` / `i_start`, so rectangles never change mid-frame.

## Interface
- `RECT_NUMMAX`, default `` `RECT_NUMMAX ``: number of rectangle slots.
- `N_REQ`, default 2: number of requesters.
- `IDX_W`, default 4: slot-index width; must satisfy 2^IDX_W ≥ RECT_NUMMAX.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst` in 1: **synchronous, active-high reset.**
- `i_vs` in 1: frame sync, level.
- `i_req_valid` in N_REQ: per-requester write request.
- `o_req_ready` in→out N_REQ: per-requester grant; a transfer occurs when valid & ready.
- `i_req_idx` in N_REQ*IDX_W: target slot, requester k at bits [k*IDX_W +: IDX_W].
- `i_req_head` in N_REQ*32: head rect {x1,y1,x2,y2} packed.
- `i_req_hair` in N_REQ*32: hair rect, same packing.
- `i_req_posi` in N_REQ*64: 8 possibility bytes.
- `o_head_wire` out RECT_NUMMAX*32: active bank, head rects.
- `o_hair_wire` out RECT_NUMMAX*32: active bank, hair rects.
- `o_posi_wire` out RECT_NUMMAX*64: active bank, possibility bytes.
- `o_start` out 1: one-cycle pulse after each bank copy.
- `o_frame_cnt` out 16: number of swaps, wraps at 0xFFFF → 0.
- `o_drop_cnt` out 8: out-of-range writes, saturates at 255.

## Operation
- **Slot format.** An all-zero slot means empty, and the overlay draws nothing for it. Slot s occupies bits [s*32 +: 32] (head, hair) and [s*64 +: 64] (posi).
- **Frame edge.** `vs_d` is registered from `i_vs`. A swap cycle is `i_vs & ~vs_d`.
- **Swap cycle.**
  - Active bank ← shadow bank (all three arrays).
  - Shadow bank cleared to zero.
  - `o_frame_cnt` incremented.
  - All `o_req_ready` forced low.
- **Arbiter.**
  - Round-robin pointer `rr` in [0, N_REQ-1].
  - On a non-swap cycle, grant goes to the first requester with valid set, searching k = rr, rr+1, … modulo N_REQ.
  - `o_req_ready` is combinational: one-hot on the granted requester, zero otherwise.
  - After a transfer from requester g, `rr` ← (g+1) mod N_REQ. With no transfer, `rr` holds.
- **Write.**
  - On a transfer with idx < RECT_NUMMAX, shadow[idx] ← {head, hair, posi}. A later write to the same slot in the same frame overwrites the earlier one.
  - idx ≥ RECT_NUMMAX: the request is accepted (handshake completes), data is discarded, and `o_drop_cnt` increments (saturating).
- **Handshake.** Requesters hold valid and data stable until ready. There is at most one transfer per cycle.
- **Reset.**
  - Both banks zero; `o_start` 0; `o_frame_cnt` 0; `o_drop_cnt` 0; `rr` 0; `o_req_ready` 0.
  - `vs_d` ← 1, so a frame already in progress at reset release does not trigger a swap.
  - Reset mid-frame discards all pending shadow writes.

## Timing
- Swap is detected in cycle T when `i_vs` = 1 at edge T and `vs_d` = 0. Active outputs show the new data from T+1.
- `o_start` is high exactly during cycle T+1, i.e. it asserts on the same edge the active data is already valid.
- A write accepted at edge W is visible on the active outputs one cycle after the first swap edge later than W.
- A request whose valid is high in swap cycle T is stalled. It competes in cycle T+1 and lands in the new (cleared) shadow bank.
- `o_req_ready` has zero-cycle latency from valid (combinational grant). Arbiter fairness bound: a continuously valid requester waits at most N_REQ-1 transfer cycles, plus swap cycles.
- `i_vs` held high produces exactly one swap. Glitch-free `i_vs` is required (synchronised upstream).

## Structure
- Shared package/define file: `RECT_NUMMAX`, slot field widths (32/32/64), and the empty-slot encoding (zero).
- One sub-module, `rr_arbiter` (N_REQ requests → one-hot grant, pointer update on transfer), reusable elsewhere.
- Bank registers, edge detect and counters live in the top.

## Test plan
1. **Reset.** Reset with `i_vs` = 1, release, hold `i_vs` high for 10 cycles → no `o_start`, all outputs 0, `o_frame_cnt` = 0.
2. **Single write.** Req0 writes idx 2, head 0x0010_0020 / hair 0x0030_0040 / posi 0x0102030405060708. Raise `i_vs` → one cycle later: slot 2 holds those values, other slots 0, `o_start` is a single pulse, `o_frame_cnt` = 1. Second frame with no writes → slot 2 reads 0.
3. **Arbitration.** Both requesters valid continuously with distinct idx → grants alternate 0,1,0,1 starting at requester 0; never two ready bits in one cycle.
4. **Swap collision.** Req1 valid exactly in the swap cycle → ready low that cycle; transfer in the next cycle; data appears only after the following swap.
5. **Out-of-range.** 300 writes with idx = RECT_NUMMAX → all handshakes complete, `o_drop_cnt` = 255, banks unchanged.
6. **Reset mid-frame.** Write idx 0, assert `sys_rst` one cycle before `i_vs` rises → after release and the next `i_vs` edge, slot 0 = 0 and `o_frame_cnt` = 1.

Source files
------------

// File: rtl/rect_frame_loader_pkg.sv
// Shared constants and types for the rectangle overlay frame loader:
// slot count, slot field widths and the empty-slot encoding.
package rect_frame_loader_pkg;

`ifndef RECT_NUMMAX
`define RECT_NUMMAX 8
`endif

   localparam int RECT_NUMMAX_DEF = `RECT_NUMMAX;

   localparam int HEAD_W = 32;
   localparam int HAIR_W = 32;
   localparam int POSI_W = 64;

   typedef struct packed {
      logic [HEAD_W-1:0] head;
      logic [HAIR_W-1:0] hair;
      logic [POSI_W-1:0] posi;
   } slot_t;

   // An all-zero slot is empty; the overlay draws nothing for it.
   localparam slot_t SLOT_EMPTY = '0;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rect_frame_loader_rr_arbiter.sv
// Round-robin arbiter: N requests -> one-hot combinational grant. The pointer
// moves past the winner whenever a grant is issued (grant implies transfer).
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_block,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant
);

   localparam int RR_W = (N > 1) ? $clog2(N) : 1;

   logic [RR_W-1:0] r_rr;
   logic [N-1:0]    w_grant;
   logic            w_found;
   logic [RR_W-1:0] w_gidx;

   // Search k = rr, rr+1, ... modulo N; the first valid requester wins.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_gidx  = '0;
      if (!i_block) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (!w_found && i_req[k] && (k == ((int'(r_rr) + i) % N))) begin
                  w_grant[k] = 1'b1;
                  w_found    = 1'b1;
                  w_gidx     = RR_W'(k);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr <= '0;
      end else if (w_found) begin
         r_rr <= (int'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/rect_frame_loader.sv
// Frame-synchronous loader for the rectangle overlay: requesters fill a shadow
// bank, and each rising frame sync copies it to the active bank in one cycle.
module rect_frame_loader
   import rect_frame_loader_pkg::*;
#(
   parameter int RECT_NUMMAX = RECT_NUMMAX_DEF,
   parameter int N_REQ       = 2,
   parameter int IDX_W       = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          i_vs,
   input  logic [N_REQ-1:0]              i_req_valid,
   output logic [N_REQ-1:0]              o_req_ready,
   input  logic [N_REQ*IDX_W-1:0]        i_req_idx,
   input  logic [N_REQ*HEAD_W-1:0]       i_req_head,
   input  logic [N_REQ*HAIR_W-1:0]       i_req_hair,
   input  logic [N_REQ*POSI_W-1:0]       i_req_posi,
   output logic [RECT_NUMMAX*HEAD_W-1:0] o_head_wire,
   output logic [RECT_NUMMAX*HAIR_W-1:0] o_hair_wire,
   output logic [RECT_NUMMAX*POSI_W-1:0] o_posi_wire,
   output logic                          o_start,
   output logic [15:0]                   o_frame_cnt,
   output logic [7:0]                    o_drop_cnt
);

   logic                          r_vs_d;
   logic [RECT_NUMMAX*HEAD_W-1:0] r_sh_head;
   logic [RECT_NUMMAX*HAIR_W-1:0] r_sh_hair;
   logic [RECT_NUMMAX*POSI_W-1:0] r_sh_posi;
   logic [RECT_NUMMAX*HEAD_W-1:0] r_act_head;
   logic [RECT_NUMMAX*HAIR_W-1:0] r_act_hair;
   logic [RECT_NUMMAX*POSI_W-1:0] r_act_posi;
   logic                          r_start;
   logic [15:0]                   r_frame_cnt;
   logic [7:0]                    r_drop_cnt;

   logic             w_swap;
   logic [N_REQ-1:0] w_grant;
   logic             w_xfer;
   logic [IDX_W-1:0] w_sel_idx;
   slot_t            w_sel;
   logic             w_in_range;

   assign w_swap = i_vs & ~r_vs_d;

   // Handshake: a transfer happens in any cycle where valid & ready for a
   // requester. Ready is a combinational one-hot grant, held low during a swap
   // and during reset; requesters keep valid and data stable until ready.
   rr_arbiter #(.N(N_REQ)) u_arb (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_block (w_swap | sys_rst),
      .i_req   (i_req_valid),
      .o_grant (w_grant)
   );

   assign o_req_ready = w_grant;
   assign w_xfer      = |w_grant;

   always_comb begin
      w_sel_idx = '0;
      w_sel     = SLOT_EMPTY;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_grant[k]) begin
            w_sel_idx = i_req_idx[k*IDX_W +: IDX_W];
            w_sel.head = i_req_head[k*HEAD_W +: HEAD_W];
            w_sel.hair = i_req_hair[k*HAIR_W +: HAIR_W];
            w_sel.posi = i_req_posi[k*POSI_W +: POSI_W];
         end
      end
   end

   assign w_in_range = (int'(w_sel_idx) < RECT_NUMMAX);

   // vs_d resets high so a frame already in progress does not trigger a swap.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_vs_d      <= 1'b1;
         r_sh_head   <= '0;
         r_sh_hair   <= '0;
         r_sh_posi   <= '0;
         r_act_head  <= '0;
         r_act_hair  <= '0;
         r_act_posi  <= '0;
         r_start     <= 1'b0;
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_vs_d  <= i_vs;
         r_start <= w_swap;
         if (w_swap) begin
            r_act_head  <= r_sh_head;
            r_act_hair  <= r_sh_hair;
            r_act_posi  <= r_sh_posi;
            r_sh_head   <= '0;
            r_sh_hair   <= '0;
            r_sh_posi   <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end else if (w_xfer) begin
            if (w_in_range) begin
               for (int s = 0; s < RECT_NUMMAX; s++) begin
                  if (w_sel_idx == IDX_W'(s)) begin
                     r_sh_head[s*HEAD_W +: HEAD_W] <= w_sel.head;
                     r_sh_hair[s*HAIR_W +: HAIR_W] <= w_sel.hair;
                     r_sh_posi[s*POSI_W +: POSI_W] <= w_sel.posi;
                  end
               end
            end else begin
               r_drop_cnt <= sat_inc8(r_drop_cnt);
            end
         end
      end
   end

   assign o_head_wire = r_act_head;
   assign o_hair_wire = r_act_hair;
   assign o_posi_wire = r_act_posi;
   assign o_start     = r_start;
   assign o_frame_cnt = r_frame_cnt;
   assign o_drop_cnt  = r_drop_cnt;

endmodule
